// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-vote bit decisions,
// configurable framing, break detection and a FWFT receive FIFO.
module uart_rx_fifo #(
  parameter int CLOCK_DIVISOR_WIDTH = 24,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic [1:0] dataBits,
  input  logic hasParity,
  input  logic [1:0] parityMode,
  input  logic extraStopBit,
  input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
  output logic [7:0] rdData,
  output logic rdParityErr,
  output logic rdFramingErr,
  output logic rdBreak,
  output logic rdValid,
  input  logic rdReady,
  output logic [$clog2(FIFO_DEPTH):0] fifoCount,
  output logic overflow,
  input  logic clearOverflow,
  output logic busy
);

  localparam int DW = CLOCK_DIVISOR_WIDTH;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [SW-1:0] S_A = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_B = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_C = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_ONE = SW'(1);
  localparam logic [DW-1:0] D_ONE = DW'(1);
  localparam logic [AW-1:0] A_ONE = AW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT
  } state_t;

  logic [SYNC_STAGES-1:0] syncQ;
  logic rxS;

  always_ff @(posedge clk) begin
    if (rst) syncQ <= '1;
    else syncQ <= {syncQ[SYNC_STAGES-2:0], rx};
  end

  assign rxS = syncQ[SYNC_STAGES-1];

  state_t state;
  logic [DW-1:0] divCnt;
  logic [SW-1:0] sampleCnt;
  logic s0, s1;
  logic [1:0] cfgBits, cfgMode;
  logic cfgPar, cfgStop2;
  logic [7:0] shiftReg;
  logic [2:0] bitIdx;
  logic parAcc, allZero, pErr, fErr;
  logic pushReq;
  logic [10:0] pushWord;

  logic inFrame, tick, decide, vote, expPar;
  logic stopFe, stopZero;
  logic [2:0] lastIdx;

  assign inFrame = (state == START) || (state == DATA) ||
                   (state == PARITY) || (state == STOP1) ||
                   (state == STOP2);
  assign tick = inFrame && (divCnt == clockDivisor);
  assign decide = tick && (sampleCnt == S_C);
  assign vote = (s0 & s1) | (s0 & rxS) | (s1 & rxS);
  assign lastIdx = {1'b0, cfgBits} + 3'd4;
  assign stopFe = fErr | ~vote;
  assign stopZero = allZero & ~vote;

  always_comb begin
    expPar = 1'b0;
    unique case (cfgMode)
      2'b01: expPar = parAcc;
      2'b10: expPar = ~parAcc;
      2'b11: expPar = 1'b1;
      default: expPar = 1'b0;
    endcase
  end

  // Counters are frozen at zero outside a frame so tick phase
  // lines up with the start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      divCnt <= '0;
      sampleCnt <= '0;
      s0 <= 1'b0;
      s1 <= 1'b0;
      cfgBits <= '0;
      cfgMode <= '0;
      cfgPar <= 1'b0;
      cfgStop2 <= 1'b0;
      shiftReg <= '0;
      bitIdx <= '0;
      parAcc <= 1'b0;
      allZero <= 1'b0;
      pErr <= 1'b0;
      fErr <= 1'b0;
      pushReq <= 1'b0;
      pushWord <= '0;
    end else begin
      pushReq <= 1'b0;
      if (!inFrame || tick) divCnt <= '0;
      else divCnt <= divCnt + D_ONE;
      if (!inFrame) sampleCnt <= '0;
      else if (tick) begin
        if (sampleCnt == S_LAST) sampleCnt <= '0;
        else sampleCnt <= sampleCnt + S_ONE;
      end
      if (tick && sampleCnt == S_A) s0 <= rxS;
      if (tick && sampleCnt == S_B) s1 <= rxS;
      unique case (state)
        IDLE: begin
          if (!rxS) begin
            cfgBits <= dataBits;
            cfgMode <= parityMode;
            cfgPar <= hasParity;
            cfgStop2 <= extraStopBit;
            shiftReg <= '0;
            bitIdx <= '0;
            parAcc <= 1'b0;
            allZero <= 1'b1;
            pErr <= 1'b0;
            fErr <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (decide) state <= vote ? IDLE : DATA;
        end
        DATA: begin
          if (decide) begin
            shiftReg[bitIdx] <= vote;
            parAcc <= parAcc ^ vote;
            allZero <= allZero & ~vote;
            bitIdx <= bitIdx + 3'd1;
            if (bitIdx == lastIdx) state <= cfgPar ? PARITY : STOP1;
          end
        end
        PARITY: begin
          if (decide) begin
            pErr <= (vote != expPar);
            allZero <= allZero & ~vote;
            state <= STOP1;
          end
        end
        STOP1, STOP2: begin
          if (decide) begin
            if (state == STOP1 && cfgStop2) begin
              fErr <= stopFe;
              allZero <= stopZero;
              state <= STOP2;
            end else begin
              pushReq <= 1'b1;
              if (stopZero) begin
                pushWord <= {1'b1, 1'b1, 1'b0, 8'h00};
                state <= BRKWAIT;
              end else begin
                pushWord <= {1'b0, stopFe, pErr, shiftReg};
                state <= IDLE;
              end
            end
          end
        end
        BRKWAIT: begin
          if (rxS) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  logic [10:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic full, pop, doWrite, drop;
  logic [10:0] head;

  assign full = (count == C_FULL);
  assign pop = rdValid && rdReady;
  assign doWrite = pushReq && (!full || pop);
  assign drop = pushReq && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst && doWrite) mem[wrPtr] <= pushWord;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + A_ONE;
      if (pop) rdPtr <= rdPtr + A_ONE;
      unique case ({doWrite, pop})
        2'b10: count <= count + C_ONE;
        2'b01: count <= count - C_ONE;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear must stay visible.
      if (drop) overflow <= 1'b1;
      else if (clearOverflow) overflow <= 1'b0;
    end
  end

  assign rdValid = (count != '0);
  assign fifoCount = count;
  assign head = rdValid ? mem[rdPtr] : '0;
  assign rdData = head[7:0];
  assign rdParityErr = head[8];
  assign rdFramingErr = head[9];
  assign rdBreak = head[10];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: serial frames in,
// expected {break, framing, parity, data} entries checked on pop.
module tb_uart_rx_fifo;

  localparam int BITC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic [1:0] dataBits = 2'd3;
  logic hasParity = 1'b0;
  logic [1:0] parityMode = 2'b00;
  logic extraStopBit = 1'b0;
  logic [23:0] clockDivisor = 24'd0;
  logic [7:0] rdData;
  logic rdParityErr, rdFramingErr, rdBreak, rdValid;
  logic rdReady = 1'b0;
  logic [3:0] fifoCount;
  logic overflow;
  logic clearOverflow = 1'b0;
  logic busy;

  int checks = 0;
  int failures = 0;
  logic [10:0] sb[$];
  logic [10:0] expW;

  uart_rx_fifo dut (
    .clk(clk), .rst(rst), .rx(rx),
    .dataBits(dataBits), .hasParity(hasParity),
    .parityMode(parityMode), .extraStopBit(extraStopBit),
    .clockDivisor(clockDivisor),
    .rdData(rdData), .rdParityErr(rdParityErr),
    .rdFramingErr(rdFramingErr), .rdBreak(rdBreak),
    .rdValid(rdValid), .rdReady(rdReady),
    .fifoCount(fifoCount), .overflow(overflow),
    .clearOverflow(clearOverflow), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && rdValid && rdReady) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_entry got=%h expected=none",
                 {rdBreak, rdFramingErr, rdParityErr, rdData});
      end else begin
        expW = sb.pop_front();
        if ({rdBreak, rdFramingErr, rdParityErr, rdData} !== expW) begin
          failures++;
          $display("FAIL entry got=%h expected=%h",
                   {rdBreak, rdFramingErr, rdParityErr, rdData}, expW);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic bitOut(input logic b);
    rx = b;
    repeat (BITC) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] d, input int n,
                           input bit parEn, input bit par,
                           input bit st1, input bit two,
                           input bit st2);
    bitOut(1'b0);
    for (int i = 0; i < n; i++) bitOut(d[i]);
    if (parEn) bitOut(par);
    bitOut(st1);
    if (two) bitOut(st2);
    rx = 1'b1;
    repeat (3 * BITC) @(posedge clk);
    #1;
  endtask

  task automatic waitValid(input string nm);
    int n;
    n = 0;
    while (!rdValid && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, {31'd0, rdValid}, 32'd1);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    rdReady = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    rdReady = 1'b0;
    chk(nm, sb.size(), 0);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'd0, rdValid}, 0);
    chk("rst_count", {28'd0, fifoCount}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_data", {24'd0, rdData}, 0);
    @(posedge clk);
    #1;

    sb.push_back({3'b000, 8'hA5});
    sendFrame(8'hA5, 8, 0, 0, 1, 0, 1);
    waitValid("a5_valid");
    chk("a5_count", {28'd0, fifoCount}, 1);
    drain("a5_drain");
    chk("a5_count0", {28'd0, fifoCount}, 0);
    chk("a5_valid0", {31'd0, rdValid}, 0);

    dataBits = 2'd2;
    hasParity = 1'b1;
    parityMode = 2'b01;
    sb.push_back({3'b001, 8'h35});
    sendFrame(8'h35, 7, 1, 1, 1, 0, 1);
    waitValid("e_bad_valid");
    drain("e_bad_drain");
    sb.push_back({3'b000, 8'h35});
    sendFrame(8'h35, 7, 1, 0, 1, 0, 1);
    waitValid("e_ok_valid");
    drain("e_ok_drain");

    dataBits = 2'd0;
    parityMode = 2'b10;
    extraStopBit = 1'b1;
    sb.push_back({3'b010, 8'h1F});
    sendFrame(8'h1F, 5, 1, 0, 1, 1, 0);
    waitValid("o2_bad_valid");
    drain("o2_bad_drain");
    sb.push_back({3'b000, 8'h1F});
    sendFrame(8'h1F, 5, 1, 0, 1, 1, 1);
    waitValid("o2_ok_valid");
    drain("o2_ok_drain");

    dataBits = 2'd3;
    hasParity = 1'b0;
    parityMode = 2'b00;
    extraStopBit = 1'b0;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    chk("glitch_busy1", {31'd0, busy}, 1);
    repeat (BITC) @(posedge clk);
    #1;
    chk("glitch_busy0", {31'd0, busy}, 0);
    chk("glitch_count", {28'd0, fifoCount}, 0);

    sb.push_back({3'b110, 8'h00});
    rx = 1'b0;
    repeat (30 * BITC) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3 * BITC) @(posedge clk);
    #1;
    chk("brk_count", {28'd0, fifoCount}, 1);
    chk("brk_busy", {31'd0, busy}, 0);
    drain("brk_drain");
    sb.push_back({3'b000, 8'h55});
    sendFrame(8'h55, 8, 0, 0, 1, 0, 1);
    waitValid("post_brk_valid");
    drain("post_brk_drain");

    for (int v = 1; v <= 9; v++) begin
      if (v <= 8) sb.push_back({3'b000, 8'(v)});
      sendFrame(8'(v), 8, 0, 0, 1, 0, 1);
    end
    chk("ovf_count", {28'd0, fifoCount}, 8);
    chk("ovf_set", {31'd0, overflow}, 1);
    drain("ovf_drain");
    chk("ovf_count0", {28'd0, fifoCount}, 0);
    chk("ovf_sticky", {31'd0, overflow}, 1);
    clearOverflow = 1'b1;
    @(posedge clk);
    #1;
    clearOverflow = 1'b0;
    chk("ovf_clear", {31'd0, overflow}, 0);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver. It oversamples the line and majority-votes each bit, supports 5–8 data bits, optional parity in four modes, and 1 or 2 stop bits. It detects false starts, framing errors, parity errors and line breaks. Received words and their per-word status are pushed into a first-word-fall-through FIFO that the host side of the serial peripheral drains.

Parameters:
CLOCK_DIVISOR_WIDTH, 24, width of the oversample-tick divisor.
OVERSAMPLE, 16, oversample ticks per bit; even, at least 8.
FIFO_DEPTH, 8, receive FIFO entries; power of 2, at least 2.
SYNC_STAGES, 2, rx synchroniser flops; at least 2.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rx  in  1  asynchronous serial input, idle high
dataBits  in  2  data bit count = dataBits + 5
hasParity  in  1  parity bit present
parityMode  in  2  00 space, 11 mark, 01 even, 10 odd
extraStopBit  in  1  0: one stop bit, 1: two stop bits
clockDivisor  in  CLOCK_DIVISOR_WIDTH  one oversample tick every clockDivisor+1 clk cycles
rdData  out  8  FIFO head data, right-aligned, unused upper bits 0
rdParityErr  out  1  head entry parity error
rdFramingErr  out  1  head entry framing error
rdBreak  out  1  head entry is a break
rdValid  out  1  FIFO not empty
rdReady  in  1  pop head when rdValid
fifoCount  out  clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky: a word was dropped
clearOverflow  in  1  clears overflow
busy  out  1  receiver not in IDLE

Behaviour:
- Reset values: all outputs 0. Synchroniser flops reset to 1. FSM goes to IDLE, FIFO empties, divisor and tick counters clear. A reset mid-frame discards the frame.
- Tick generator: counts 0..clockDivisor and emits a 1-clk tick at the wrap. It is held at 0 in IDLE, so tick phase aligns to the start edge.
- Per bit: a sample counter runs 0..OVERSAMPLE-1 on ticks. The bit value is the majority of synced rx at counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit is decided at count OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT.
- IDLE: on synced rx=0, latch dataBits, hasParity, parityMode and extraStopBit for the whole frame, then go to START. Input changes mid-frame are ignored.
- START: if the voted bit is 1, it is a false start; return to IDLE with no push. Otherwise go to DATA.
- DATA: LSB first, for dataBits+5 bits. Then go to PARITY if parity is enabled, else STOP1.
- PARITY check: the expected bit is even = XOR of data, odd = inverted XOR, mark = 1, space = 0. A mismatch sets parityErr.
- STOP1: a voted 0 sets framingErr. Go to STOP2 if extraStopBit, else finish.
- STOP2: a voted 0 sets framingErr, then finish.
- Finish happens at the stop-bit decision point, not at bit end:
  - If the data, parity and all stop bits sampled were 0, push data=0 with break=1 and framingErr=1, then go to BRKWAIT.
  - Otherwise push the word with its flags and go to IDLE. A start edge within the rest of the stop bit is detected.
- BRKWAIT: stay until synced rx=1, then go to IDLE. Exactly one entry is pushed per break, whatever its length.
- FIFO: rdData and flags show the head combinationally from storage while rdValid. Pop when rdValid && rdReady.
- Pushed entries appear on rdValid/fifoCount one clk after the push cycle.
- Push when full:
  - With no pop in the same cycle, the new entry is dropped, FIFO contents are unchanged and overflow sets.
  - With a pop in the same cycle, both happen and count is unchanged.
- Pop when empty is ignored. Read and write pointers wrap modulo FIFO_DEPTH.
- overflow: clearOverflow clears it. If a drop and clearOverflow occur in the same cycle, overflow ends set.
- busy = (state != IDLE).

Test Plan:
- 8N1, clockDivisor=0, OVERSAMPLE=16: send 0xA5 → rdValid rises; rdData=0xA5, all flags 0, fifoCount=1. Pulse rdReady → fifoCount=0, rdValid=0.
- 7E1: send 0x35 with parity bit 1 (correct value is 0) → rdData=0x35, rdParityErr=1. Resend with parity 0 → rdParityErr=0.
- 5O2: send 0x1F with the second stop bit 0 → rdData=0x1F, rdFramingErr=1. With both stops 1 → no error.
- Glitch: rx low for 4 ticks, then high → no push, busy returns to 0 within 1 bit time, fifoCount=0.
- Break, 8N1: rx low for 30 bit times, then high → exactly one entry (data 0x00, rdBreak=1, rdFramingErr=1). A following 0x55 is received correctly.
- Overflow, FIFO_DEPTH=8, no reads: send 0x01..0x09 → fifoCount=8, overflow=1, entries read back 0x01..0x08. Pulse clearOverflow → overflow=0.
